mul_result_collector: RTL and testbench
=======================================

MUL_RESULT_COLLECTOR -- requirements
Module: mul_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, record FIFO depth; SHALL be a power of two, 2..16.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-003 Port rst  input  1  synchronous, active-high reset; SHALL be sampled only on rising clk.
REQ-004 Port in_grant  input  1  high for one cycle with the first product (d*1) of a group.
REQ-005 Port in_data  input  11  product stream; d*1, d*3, d*7, d*8 on four consecutive cycles starting at the in_grant cycle.
REQ-006 Port out_valid  output  1  FIFO non-empty; head record presented.
REQ-007 Port out_ready  input  1  consumer accepts head record when out_valid & out_ready.
REQ-008 Port out_base  output  8  head record base value d.
REQ-009 Port out_sum  output  13  head record sum of the four products.
REQ-010 Port out_err  output  1  head record failed the product consistency check.
REQ-011 Port overflow  output  1  sticky; a completed record was dropped because the FIFO was full.
REQ-012 Port drop_cnt  output  8  dropped-record count; saturates at 255.
REQ-013 Port resync_cnt  output  8  aborted-group count; saturates at 255.

Function
REQ-014 The collector SHALL be a four-state FSM: IDLE, P1, P2, P3.
- IDLE: in_grant=1 -> capture in_data as p0, go to P1; otherwise in_data is ignored.
- P1 and P2: capture in_data as p1 or p2 respectively, go to the next state.
- P3: use in_data as p3, push the record, go to IDLE.
REQ-015 in_grant=1 in P1, P2 or P3 SHALL abort the partial group without a push, increment resync_cnt, capture in_data as the new p0 and go to P1.
REQ-016 Record fields SHALL be base=p0[7:0] and sum=p0+p1+p2+p3, computed at 13 bits with no truncation.
REQ-017 err SHALL be 1 iff p0[10:8]!=0 or p1!=3*base or p2!=7*base or p3!=8*base, all compared at 11 bits.
REQ-018 Latency: for grant sampled at edge T0, the push SHALL occur at edge T3; out_valid SHALL be high after T3 if the FIFO was empty.
REQ-019 Back-to-back groups with a grant at T4 SHALL be accepted with no lost cycle.
REQ-020 FIFO SHALL be show-ahead: out_base, out_sum and out_err reflect the head whenever out_valid=1, and hold their last value when out_valid=0.
REQ-021 Pop SHALL occur at an edge where out_valid & out_ready; head data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Push while full and no pop in the same cycle SHALL drop the new record, set overflow, and increment drop_cnt (saturating at 255); FIFO contents SHALL be unchanged.
REQ-023 Push and pop in the same cycle while full SHALL both take effect; no drop, occupancy unchanged.
REQ-024 Push and pop in the same cycle while holding one entry SHALL leave out_valid=1 with the new record at the head.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst=1 at an edge SHALL force FSM=IDLE, empty FIFO, out_valid=0, out_base=0, out_sum=0, out_err=0, overflow=0, drop_cnt=0, resync_cnt=0.
REQ-028 rst SHALL take priority over in_grant, push and pop in the same cycle.
REQ-029 A partial group interrupted by rst SHALL be discarded without counting a resync.
REQ-030 After reset release, the first in_grant SHALL be accepted in the first cycle rst=0.

Verification
REQ-031 Single group, d=5: in_data 5,15,35,40 -> out_valid after T3, base=5, sum=95, err=0.
REQ-032 Single group, d=255: in_data 255,765,1785,2040 -> sum=4845, err=0.
REQ-033 Corrupted group, d=5 with p2=36 -> sum=96, err=1.
REQ-034 Six groups with out_ready=0 and DEPTH=4 -> four records held, overflow=1, drop_cnt=2; then out_ready=1 -> the four original records drain in order.
REQ-035 Grant reasserted in P2 -> resync_cnt=1, no record for the aborted group, next complete group is correct.
REQ-036 rst pulsed in P2 with two records queued -> out_valid=0, counters 0, next group output correct.

Source files
------------

// File: rtl/mul_result_collector.sv
// Collects four-beat product groups (d*1, d*3, d*7, d*8) into {base, sum, err} records
// and queues them in a show-ahead FIFO with drop/resync accounting.
module mul_result_collector #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_grant,
    input  logic [10:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_base,
    output logic [12:0] out_sum,
    output logic        out_err,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  resync_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = 22;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        P3   = 2'd3
    } state_t;

    // Record layout {base[7:0], sum[12:0], err}; err flags any product that disagrees with base.
    function automatic logic [REC_W-1:0] make_rec(
        input logic [10:0] p0,
        input logic [10:0] p1,
        input logic [10:0] p2,
        input logic [10:0] p3
    );
        logic [7:0]  base;
        logic [10:0] b8;
        logic [10:0] b1;
        logic [12:0] sum;
        logic        err;
        base = p0[7:0];
        b1   = {3'b000, base};
        b8   = {base, 3'b000};
        sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
        err  = (p0[10:8] != 3'b000) || (p1 != (b1 + {b1[9:0], 1'b0}))
            || (p2 != (b8 - b1)) || (p3 != b8);
        return {base, sum, err};
    endfunction

    state_t            state_r, state_nxt_s;
    logic [10:0]       p0_r, p1_r, p2_r;
    logic              cap_p1_s, cap_p2_s, push_s, resync_s;
    logic [REC_W-1:0]  new_rec_s;

    logic [REC_W-1:0]  mem_r [DEPTH];
    logic [AW-1:0]     rd_ptr_r, wr_ptr_r, rd_nxt_ptr_s;
    logic [CW-1:0]     count_r, count_nxt_s;
    logic              out_valid_r, pop_s, do_push_s, drop_s;
    logic              head_load_s;
    logic [REC_W-1:0]  head_nxt_s, head_r;
    logic              overflow_r;
    logic [7:0]        drop_cnt_r, resync_cnt_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a grant always (re)starts a group.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (in_grant) state_nxt_s = P1; else state_nxt_s = IDLE;
            P1:      if (in_grant) state_nxt_s = P1; else state_nxt_s = P2;
            P2:      if (in_grant) state_nxt_s = P1; else state_nxt_s = P3;
            P3:      if (in_grant) state_nxt_s = P1; else state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: capture enables, record push and resync detection.
    always_comb begin
        cap_p1_s = 1'b0;
        cap_p2_s = 1'b0;
        push_s   = 1'b0;
        resync_s = 1'b0;
        case (state_r)
            IDLE:    resync_s = 1'b0;
            P1:      begin resync_s = in_grant; cap_p1_s = !in_grant; end
            P2:      begin resync_s = in_grant; cap_p2_s = !in_grant; end
            P3:      begin resync_s = in_grant; push_s   = !in_grant; end
            default: resync_s = 1'b0;
        endcase
    end

    // Product capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_r <= 11'd0;
            p1_r <= 11'd0;
            p2_r <= 11'd0;
        end else begin
            if (in_grant) p0_r <= in_data;
            if (cap_p1_s) p1_r <= in_data;
            if (cap_p2_s) p2_r <= in_data;
        end
    end

    assign new_rec_s    = make_rec(p0_r, p1_r, p2_r, in_data);
    assign pop_s        = out_valid_r && out_ready;
    assign do_push_s    = push_s && ((count_r != FULL_CNT) || pop_s);
    assign drop_s       = push_s && (count_r == FULL_CNT) && !pop_s;
    assign rd_nxt_ptr_s = rd_ptr_r + AW'(1);

    // Occupancy update.
    always_comb begin
        case ({do_push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next head: the following entry on pop, or the new record when it lands in an empty slot.
    always_comb begin
        head_load_s = 1'b0;
        head_nxt_s  = head_r;
        if (pop_s && (count_r > CW'(1))) begin
            head_load_s = 1'b1;
            head_nxt_s  = mem_r[rd_nxt_ptr_s];
        end else if (do_push_s && ((count_r == CW'(0)) || (pop_s && (count_r == CW'(1))))) begin
            head_load_s = 1'b1;
            head_nxt_s  = new_rec_s;
        end else begin
            head_load_s = 1'b0;
            head_nxt_s  = head_r;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst && do_push_s) begin
            mem_r[wr_ptr_r] <= new_rec_s;
        end
    end

    // FIFO pointers, head register, status and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            out_valid_r  <= 1'b0;
            head_r       <= '0;
            overflow_r   <= 1'b0;
            drop_cnt_r   <= 8'd0;
            resync_cnt_r <= 8'd0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)     rd_ptr_r <= rd_nxt_ptr_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != CW'(0));
            if (head_load_s) head_r <= head_nxt_s;
            if (drop_s) overflow_r <= 1'b1;
            if (drop_s && (drop_cnt_r != 8'hFF))     drop_cnt_r   <= drop_cnt_r + 8'd1;
            if (resync_s && (resync_cnt_r != 8'hFF)) resync_cnt_r <= resync_cnt_r + 8'd1;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_base   = head_r[21:14];
    assign out_sum    = head_r[13:1];
    assign out_err    = head_r[0];
    assign overflow   = overflow_r;
    assign drop_cnt   = drop_cnt_r;
    assign resync_cnt = resync_cnt_r;

endmodule

// File: tb/tb_mul_result_collector.sv
// Scoreboard bench for mul_result_collector: expected records are queued at stimulus time
// and compared against the FIFO head every cycle it is valid.
module tb_mul_result_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_grant;
    logic [10:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_base;
    logic [12:0] out_sum;
    logic        out_err;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [7:0]  resync_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int exp_q[$];
    int exp_drop   = 0;
    int exp_resync = 0;
    int last_rec   = 0;
    bit rand_ready = 1'b0;

    mul_result_collector #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_grant   (in_grant),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_base   (out_base),
        .out_sum    (out_sum),
        .out_err    (out_err),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_rec(input int w0, input int w1, input int w2, input int w3);
        int base, sum, err;
        base = w0 % 256;
        sum  = w0 + w1 + w2 + w3;
        err  = ((w0 / 256) != 0 || w1 != 3 * base || w2 != 7 * base || w3 != 8 * base) ? 1 : 0;
        return (base << 14) | (sum << 1) | err;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one full group; corrupt word cidx (0..3) with cval, cidx>3 means clean.
    task automatic send_group(input int d, input int cidx, input int cval);
        int w[4];
        w[0] = d; w[1] = 3 * d; w[2] = 7 * d; w[3] = 8 * d;
        if (cidx < 4) w[cidx] = cval;
        for (int k = 0; k < 4; k++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            in_grant = (k == 0);
            in_data  = 11'(w[k]);
            if (k == 3) begin
                if (exp_q.size() == 0) check("lat_pre_T3", int'(out_valid), 0);
                if (exp_q.size() == DEPTH && !out_ready) exp_drop++;
                else exp_q.push_back(model_rec(w[0], w[1], w[2], w[3]));
            end
            step();
        end
        in_grant = 1'b0;
        in_data  = 11'd0;
    endtask

    task automatic partial_group(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            in_grant = (k == 0);
            in_data  = 11'(d * (k == 0 ? 1 : (k == 1 ? 3 : 7)));
            step();
        end
    endtask

    task automatic drain();
        int cyc;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
        step();
        check("drain_valid_low", int'(out_valid), 0);
        check("hold_last", int'({out_base, out_sum, out_err}), last_rec);
    endtask

    // Head comparison every valid cycle; pops mirror the DUT handshake.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", int'(out_valid), 0);
            end else begin
                check("head", int'({out_base, out_sum, out_err}), exp_q[0]);
                if (out_ready) last_rec = exp_q.pop_front();
            end
        end
    end

    initial begin
        rst = 1'b1; in_grant = 1'b0; in_data = 11'd0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", int'(out_valid), 0);
        check("rst_fields", int'({out_base, out_sum, out_err}), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_drop", int'(drop_cnt), 0);
        check("rst_resync", int'(resync_cnt), 0);

        // d=5 with consumer stalled, first grant in the first cycle after reset release
        rst = 1'b0;
        send_group(5, 4, 0);
        check("lat_T3_valid", int'(out_valid), 1);
        check("d5_sum", int'(out_sum), 95);
        step();
        check("stall_hold", int'(out_base), 5);
        drain();

        // Back-to-back: d=255, corrupted p2, nonzero p0 upper bits
        out_ready = 1'b1;
        send_group(255, 4, 0);
        send_group(5, 2, 36);
        send_group(5, 0, 256 + 5);
        send_group(0, 4, 0);
        drain();
        check("d255_seen_order_last", last_rec, model_rec(0, 0, 0, 0));

        // Six groups into a stalled depth-4 FIFO
        out_ready = 1'b0;
        for (int g = 0; g < 6; g++) send_group(10 + g, 4, 0);
        check("fill_overflow", int'(overflow), 1);
        check("fill_drop", int'(drop_cnt), exp_drop);
        check("fill_drop_two", int'(drop_cnt), 2);
        drain();

        // Grant reasserted in P2 aborts the group
        out_ready = 1'b1;
        partial_group(77, 2);
        exp_resync++;
        send_group(9, 4, 0);
        check("resync_cnt", int'(resync_cnt), exp_resync);
        drain();

        // Random back-to-back groups with a random consumer
        rand_ready = 1'b1;
        for (int g = 0; g < 12; g++) begin
            send_group($urandom_range(0, 255), $urandom_range(0, 6), $urandom_range(0, 2047));
        end
        drain();
        check("rand_drop", int'(drop_cnt), exp_drop);
        check("rand_overflow", int'(overflow), (exp_drop != 0) ? 1 : 0);

        // Reset during P2 with two records queued
        out_ready = 1'b0;
        send_group(20, 4, 0);
        send_group(21, 4, 0);
        partial_group(22, 2);
        rst = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        exp_resync = 0;
        step();
        check("rst2_valid", int'(out_valid), 0);
        check("rst2_fields", int'({out_base, out_sum, out_err}), 0);
        check("rst2_overflow", int'(overflow), 0);
        check("rst2_drop", int'(drop_cnt), 0);
        check("rst2_resync", int'(resync_cnt), 0);
        rst = 1'b0;
        last_rec = 0;
        send_group(33, 4, 0);
        check("post_rst_valid", int'(out_valid), 1);
        drain();
        check("post_rst_resync", int'(resync_cnt), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
